// File: rtl/fft_rot_addr_gen_if.sv
// ---------------------------------------------------------------------------
// fft_rot_addr_gen_if
//   Handshake/address bundle between the FFT control side and the rotating
//   address generator.
//
//   start          control -> generator   begin a sweep (sampled in IDLE)
//   mode[1:0]      control -> generator   00 rotl, 01 rotr, 10 bit-reverse,
//                                         11 same as 00
//   ready          sink    -> generator   downstream accepts addr this cycle
//   valid          generator -> sink      addr/stage/flags are meaningful
//   addr[N_BITS]   generator -> sink      rotated / bit-reversed index
//   stage[SW]      generator -> sink      current stage number
//   last_in_stage  generator -> sink      final index of the current stage
//   last           generator -> sink      final transfer of the sweep
//   busy           generator -> control   sweep in progress
//   done           generator -> control   one-cycle pulse after final transfer
//
//   master: the address generator.  slave: its environment.
// ---------------------------------------------------------------------------
interface fft_rot_addr_gen_if #(
    parameter int N_BITS = 5,
    parameter int SW     = 3
);
    logic              start;
    logic [1:0]        mode;
    logic              ready;
    logic              valid;
    logic [N_BITS-1:0] addr;
    logic [SW-1:0]     stage;
    logic              last_in_stage;
    logic              last;
    logic              busy;
    logic              done;

    modport master (
        input  start, mode, ready,
        output valid, addr, stage, last_in_stage, last, busy, done
    );

    modport slave (
        output start, mode, ready,
        input  valid, addr, stage, last_in_stage, last, busy, done
    );
endinterface

// File: rtl/fft_rot_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_rot_addr_gen
//   Sweeps every radix-2 FFT stage and emits one address per valid/ready
//   transfer. Within a stage the running index `count` goes 0..2^N_BITS-1;
//   the emitted address is count rotated left/right by the stage number
//   (mod N_BITS), or count bit-reversed for the single-pass mode.
//
//   Ports:
//     clk    clock, all logic on the rising edge
//     clr_n  synchronous active-low reset
//     bus    fft_rot_addr_gen_if.master (start/mode/ready in,
//            valid/addr/stage/last_in_stage/last/busy/done out)
//
//   Parameters:
//     N_BITS      log2 of FFT size and address width (2..16)
//     NUM_STAGES  stages swept per rotate run (1..N_BITS)
//     SW          stage-index width, 2^SW >= NUM_STAGES
// ---------------------------------------------------------------------------
module fft_rot_addr_gen #(
    parameter int N_BITS     = 5,
    parameter int NUM_STAGES = 5,
    parameter int SW         = 3
) (
    input logic                clk,
    input logic                clr_n,
    fft_rot_addr_gen_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_ROTL     = 2'b00,
        MODE_ROTR     = 2'b01,
        MODE_BREV     = 2'b10,
        MODE_ROTL_ALT = 2'b11
    } mode_t;

    localparam logic [N_BITS-1:0] COUNT_MAX = '1;
    localparam logic [SW-1:0]     STAGE_MAX = SW'(NUM_STAGES - 1);

    // ------------------------------------------------------------------
    // Address mapping helpers
    // ------------------------------------------------------------------
    // Rotation via a doubled word: the wrapped bits fall out of the
    // opposite half, so no per-amount mux tree has to be written by hand.
    function automatic logic [N_BITS-1:0] rot_left(
        input logic [N_BITS-1:0] x,
        input int                amt
    );
        logic [2*N_BITS-1:0] d;
        d = {x, x} << amt;
        return d[2*N_BITS-1:N_BITS];
    endfunction

    function automatic logic [N_BITS-1:0] rot_right(
        input logic [N_BITS-1:0] x,
        input int                amt
    );
        logic [2*N_BITS-1:0] d;
        d = {x, x} >> amt;
        return d[N_BITS-1:0];
    endfunction

    function automatic logic [N_BITS-1:0] bit_rev(input logic [N_BITS-1:0] x);
        logic [N_BITS-1:0] r;
        for (int i = 0; i < N_BITS; i++) begin
            r[i] = x[N_BITS-1-i];
        end
        return r;
    endfunction

    function automatic logic [N_BITS-1:0] map_addr(
        input logic [N_BITS-1:0] cnt,
        input logic [SW-1:0]     stg,
        input mode_t             m
    );
        int amt;
        amt = int'(stg) % N_BITS;
        case (m)
            MODE_ROTR: return rot_right(cnt, amt);
            MODE_BREV: return bit_rev(cnt);
            default:   return rot_left(cnt, amt);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state, state_next;
    mode_t             mode_r, mode_next;
    logic [N_BITS-1:0] count, count_next;
    logic [SW-1:0]     stage, stage_next;
    logic [N_BITS-1:0] addr_r, addr_next;

    logic [SW-1:0]     last_stage;
    logic              valid_int;
    logic              xfer;
    logic              end_of_stage;
    logic              end_of_sweep;

    // Bit-reverse is a single pass, so its sweep ends after stage 0.
    assign last_stage   = (mode_r == MODE_BREV) ? '0 : STAGE_MAX;
    assign valid_int    = (state == RUN);
    assign xfer         = valid_int && bus.ready;
    assign end_of_stage = (count == COUNT_MAX);
    assign end_of_sweep = end_of_stage && (stage == last_stage);

    // Process 1: state register.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here; clr_n is only looked at on an
        // edge, so it must be held across a rising clock to take effect.
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Process 2: next-state logic.
    always_comb begin
        // NOTE: default first, so no path through the case leaves
        // state_next unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (xfer && end_of_sweep) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values. addr is derived from the *next* count/stage so
    // the registered address lines up with the transfer that follows.
    always_comb begin
        mode_next  = mode_r;
        count_next = count;
        stage_next = stage;
        if (state == IDLE && bus.start) begin
            mode_next  = mode_t'(bus.mode);
            count_next = '0;
            stage_next = '0;
        end else if (xfer) begin
            if (end_of_sweep) begin
                count_next = '0;
                stage_next = '0;
            end else if (end_of_stage) begin
                count_next = '0;
                stage_next = stage + SW'(1);
            end else begin
                count_next = count + N_BITS'(1);
            end
        end
        addr_next = map_addr(count_next, stage_next, mode_next);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            mode_r <= MODE_ROTL;
            count  <= '0;
            stage  <= '0;
            addr_r <= '0;
        end else begin
            mode_r <= mode_next;
            count  <= count_next;
            stage  <= stage_next;
            addr_r <= addr_next;
        end
    end

    // Process 3: outputs. Everything is a decode of registered state, so
    // addr/stage/flags hold exactly while ready is low.
    always_comb begin
        bus.valid         = valid_int;
        bus.busy          = valid_int;
        bus.done          = (state == DONE);
        bus.addr          = addr_r;
        bus.stage         = stage;
        bus.last_in_stage = valid_int && end_of_stage;
        bus.last          = valid_int && end_of_sweep;
    end

endmodule

// File: tb/tb_fft_rot_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_fft_rot_addr_gen
//   Self-checking bench for fft_rot_addr_gen (N_BITS=5, NUM_STAGES=5, SW=3).
//   Expected transfers come from an index-based model: transfer k of a sweep
//   has stage k/32 and count k%32, and its address is computed with plain
//   integer rotate / bit-reverse arithmetic.
// ---------------------------------------------------------------------------
module tb_fft_rot_addr_gen;

    localparam int N    = 5;
    localparam int NS   = 5;
    localparam int SW   = 3;
    localparam int SIZE = 1 << N;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;

    always #5 clk = ~clk;

    fft_rot_addr_gen_if #(.N_BITS(N), .SW(SW)) bus ();

    fft_rot_addr_gen #(
        .N_BITS    (N),
        .NUM_STAGES(NS),
        .SW        (SW)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    function automatic int ref_addr(input int m, input int c, input int s);
        int a;
        int r;
        a = s % N;
        r = 0;
        case (m)
            1: r = ((c >> a) | (c << (N - a))) & (SIZE - 1);
            2: for (int i = 0; i < N; i++) if (((c >> i) & 1) == 1) r = r | (1 << (N - 1 - i));
            default: r = ((c << a) | (c >> (N - a))) & (SIZE - 1);
        endcase
        return r;
    endfunction

    // Hand-worked addresses for specific transfers (index = stage*32+count).
    function automatic int spot_addr(input int m, input int idx);
        case (m)
            0: case (idx) 51: return 7;  97: return 8;  default: return -1; endcase
            1: case (idx) 33: return 16; 131: return 6; default: return -1; endcase
            2: case (idx) 1: return 16; 6: return 12; 31: return 31; default: return -1; endcase
            default: return -1;
        endcase
    endfunction

    function automatic logic [12:0] obs_all();
        return {bus.valid, bus.busy, bus.done, bus.addr, bus.stage, bus.last_in_stage, bus.last};
    endfunction

    function automatic logic [4:0] obs_ctl();
        return {bus.valid, bus.busy, bus.done, bus.last_in_stage, bus.last};
    endfunction

    // ---------------- generic sweep ----------------
    // Entered and left at a falling edge with the DUT in IDLE.
    // ready_mode: 0 = always 1, 1 = random, 2 = stall twice at stage 2 count 10.
    task automatic run_sweep(input int m, input int ready_mode, input string tag);
        int          total, idx, cycles, stalls, s, c, ls, sp;
        logic [12:0] e;
        logic        rdy;
        total = (m == 2) ? SIZE : NS * SIZE;
        ls    = (m == 2) ? 0 : NS - 1;

        n_checks++;
        if (obs_ctl() !== 5'b00000)
            $display("FAIL %s_idle_before_start got=%b want=00000", tag, obs_ctl());
        else n_pass++;

        bus.start = 1'b1;
        bus.mode  = 2'(m);
        bus.ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);

        idx = 0; cycles = 0; stalls = 0;
        while (idx < total && cycles < 20 * total) begin
            s = idx / SIZE;
            c = idx % SIZE;
            e = {1'b1, 1'b1, 1'b0, N'(ref_addr(m, c, s)), SW'(s),
                 (c == SIZE - 1), (c == SIZE - 1) && (s == ls)};
            n_checks++;
            if (obs_all() !== e)
                $display("FAIL %s_xfer idx=%0d got=%b want=%b", tag, idx, obs_all(), e);
            else n_pass++;

            sp = spot_addr(m, idx);
            if (sp >= 0) begin
                n_checks++;
                if (bus.addr !== N'(sp))
                    $display("FAIL %s_spot idx=%0d got=%0d want=%0d", tag, idx, bus.addr, sp);
                else n_pass++;
            end

            case (ready_mode)
                0: rdy = 1'b1;
                2: begin
                    rdy = !(idx == 2 * SIZE + 10 && stalls < 2);
                    if (!rdy) stalls++;
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.ready = rdy;
            // start and mode must have no effect while running.
            bus.start = 1'($urandom_range(0, 1));
            bus.mode  = 2'($urandom_range(0, 3));
            @(posedge clk);
            if (rdy) idx++;
            cycles++;
            @(negedge clk);
        end

        n_checks++;
        if (idx != total)
            $display("FAIL %s_timeout transfers=%0d want=%0d", tag, idx, total);
        else n_pass++;

        // DONE cycle: pulse visible, start held high to show it is ignored.
        n_checks++;
        if (obs_ctl() !== 5'b00100)
            $display("FAIL %s_done_pulse got=%b want=00100", tag, obs_ctl());
        else n_pass++;
        bus.start = 1'b1;
        bus.ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);

        n_checks++;
        if (obs_ctl() !== 5'b00000)
            $display("FAIL %s_back_to_idle got=%b want=00000", tag, obs_ctl());
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clr_n = 1'b0; bus.start = 1'b1; bus.mode = 2'b01; bus.ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_all() !== 13'd0)
            $display("FAIL reset_outputs got=%b want=0", obs_all());
        else n_pass++;
        clr_n = 1'b1; bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs_all() !== 13'd0)
            $display("FAIL reset_idle_hold got=%b want=0", obs_all());
        else n_pass++;
    endtask

    task automatic test_idle_gap();
        int bad;
        bad = 0;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (obs_ctl() !== 5'b00000) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL idle_gap bad_cycles=%0d want=0", bad);
        else n_pass++;
    endtask

    task automatic test_mode_rotl();     run_sweep(0, 0, "rotl");   endtask
    task automatic test_mode_rotr();     run_sweep(1, 0, "rotr");   endtask
    task automatic test_mode_bitrev();   run_sweep(2, 0, "bitrev"); endtask

    // Sweeps chained with start high on the IDLE cycle that follows done.
    task automatic test_back_to_back();
        run_sweep(0, 2, "backpressure");
        run_sweep(3, 1, "mode11");
        run_sweep(1, 1, "rotr_rand");
        run_sweep(2, 1, "bitrev_rand");
    endtask

    task automatic test_abort();
        int idx, bad;
        bus.start = 1'b1; bus.mode = 2'b00; bus.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        idx = 0;
        while (idx < 2 * SIZE + 17) begin
            @(posedge clk);
            idx++;
            @(negedge clk);
        end
        n_checks++;
        if ({bus.valid, bus.addr, bus.stage} !== {1'b1, N'(ref_addr(0, 17, 2)), SW'(2)})
            $display("FAIL abort_position got=%b want=%b", {bus.valid, bus.addr, bus.stage},
                     {1'b1, N'(ref_addr(0, 17, 2)), SW'(2)});
        else n_pass++;

        clr_n = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs_all() !== 13'd0)
            $display("FAIL abort_outputs got=%b want=0", obs_all());
        else n_pass++;

        clr_n = 1'b1; bus.start = 1'b0;
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL abort_no_done bad_cycles=%0d want=0", bad);
        else n_pass++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_mode_rotl();
        test_idle_gap();
        test_mode_rotr();
        test_idle_gap();
        test_mode_bitrev();
        test_back_to_back();
        test_idle_gap();
        test_abort();
        run_sweep(0, 1, "after_abort");
        test_idle_gap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
